// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM encoding, bus widths and the address-window decode helper.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } wb_state_e;

    // True when adr falls in the 4*2^aw byte window anchored at base (low aw+2 bits ignored).
    function automatic logic wb_hit(input logic [31:0] adr, input logic [31:0] base,
                                    input int unsigned aw);
        logic [31:0] mask_v;
        mask_v = 32'hFFFF_FFFF << (aw + 32'd2);
        return (((adr ^ base) & mask_v) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic single-access slave in front of a synchronous single-port 32-bit SRAM,
// with byte-lane writes, parameterised read latency and optional out-of-window error.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter int          ERR_ENABLE   = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic [31:0]             wbs_adr_i,
    input  logic [WB_DW-1:0]        wbs_dat_i,
    output logic [WB_DW-1:0]        wbs_dat_o,
    input  logic                    wbs_we_i,
    input  logic [WB_SELW-1:0]      wbs_sel_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic                    ram_en_o,
    output logic [WB_SELW-1:0]      ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [WB_DW-1:0]        ram_wdata_o,
    input  logic [WB_DW-1:0]        ram_rdata_i
);

    generate
        if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
            $error("wb_sram_slave: READ_LATENCY must be in 1..4");
        end
    endgenerate

    localparam logic [1:0] CNT_INIT_C = 2'(READ_LATENCY - 1);
    localparam logic       ERR_EN_C   = (ERR_ENABLE != 0);

    wb_state_e             state_r, state_nxt_s;
    logic [1:0]            cnt_r, cnt_nxt_s;
    logic                  ack_r, ack_nxt_s;
    logic                  err_r, err_nxt_s;
    logic [WB_DW-1:0]      dat_r, dat_nxt_s;
    logic                  ram_en_r, ram_en_nxt_s;
    logic [WB_SELW-1:0]    ram_we_r, ram_we_nxt_s;
    logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_nxt_s;
    logic [WB_DW-1:0]      ram_wdata_r, ram_wdata_nxt_s;
    logic                  req_s;
    logic                  hit_s;

    assign req_s = wbs_cyc_i & wbs_stb_i;
    assign hit_s = wb_hit(wbs_adr_i, BASE_ADDR, ADDR_WIDTH);

    // Next-state and next-output decode; pulses (ack/err/ram_en/ram_we) default low every cycle.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        ack_nxt_s       = 1'b0;
        err_nxt_s       = 1'b0;
        dat_nxt_s       = dat_r;
        ram_en_nxt_s    = 1'b0;
        ram_we_nxt_s    = 4'b0000;
        ram_addr_nxt_s  = ram_addr_r;
        ram_wdata_nxt_s = ram_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (!hit_s && ERR_EN_C) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_RESP;
                    end else if (wbs_we_i) begin
                        ram_en_nxt_s    = 1'b1;
                        ram_we_nxt_s    = wbs_sel_i;
                        ram_addr_nxt_s  = wbs_adr_i[ADDR_WIDTH+1:2];
                        ram_wdata_nxt_s = wbs_dat_i;
                        ack_nxt_s       = 1'b1;
                        state_nxt_s     = ST_RESP;
                    end else begin
                        ram_en_nxt_s   = 1'b1;
                        ram_addr_nxt_s = wbs_adr_i[ADDR_WIDTH+1:2];
                        cnt_nxt_s      = CNT_INIT_C;
                        state_nxt_s    = ST_RD_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // A master that withdraws mid-read gets no termination at all.
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r != 2'd0) begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end else begin
                    dat_nxt_s   = ram_rdata_i;
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            dat_r       <= '0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 4'b0000;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ack_r       <= ack_nxt_s;
            err_r       <= err_nxt_s;
            dat_r       <= dat_nxt_s;
            ram_en_r    <= ram_en_nxt_s;
            ram_we_r    <= ram_we_nxt_s;
            ram_addr_r  <= ram_addr_nxt_s;
            ram_wdata_r <= ram_wdata_nxt_s;
        end
    end

    assign wbs_ack_o   = ack_r;
    assign wbs_err_o   = err_r;
    assign wbs_dat_o   = dat_r;
    assign ram_en_o    = ram_en_r;
    assign ram_we_o    = ram_we_r;
    assign ram_addr_o  = ram_addr_r;
    assign ram_wdata_o = ram_wdata_r;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: two instances (default build, and 4-cycle latency with aliasing),
// directed and random accesses checked against a word-array model of the window.
module tb_wb_sram_slave;

    logic        wb_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] adr    = 32'h0;
    logic [31:0] wdat   = 32'h0;
    logic        we     = 1'b0;
    logic [3:0]  sel    = 4'h0;
    logic [1:0]  cyc    = 2'b00;
    logic [1:0]  stb    = 2'b00;

    logic [1:0]  ack, err, en;
    logic [31:0] dat_o     [2];
    logic [3:0]  ram_we    [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [9:0]  ram_addr0;
    logic [7:0]  ram_addr1;

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [256];
    logic [31:0] ref0 [1024];
    logic [31:0] ref1 [256];
    logic [31:0] last_rd [2];

    int checks = 0;
    int errors = 0;

    always #5 wb_clk = ~wb_clk;

    wb_sram_slave dut0 (
        .wb_clk_i(wb_clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat_o[0]), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb[0]),
        .wbs_cyc_i(cyc[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .ram_en_o(en[0]),
        .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata[0]),
        .ram_rdata_i(ram_rdata[0])
    );

    wb_sram_slave #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0001_0000), .READ_LATENCY(4), .ERR_ENABLE(0)) dut1 (
        .wb_clk_i(wb_clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat_o[1]), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb[1]),
        .wbs_cyc_i(cyc[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .ram_en_o(en[1]),
        .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr1), .ram_wdata_o(ram_wdata[1]),
        .ram_rdata_i(ram_rdata[1])
    );

    // SRAM behavioural models: read data follows the held address, byte writes land on the edge.
    assign ram_rdata[0] = mem0[ram_addr0];
    assign ram_rdata[1] = mem1[ram_addr1];

    always @(posedge wb_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (en[0] && ram_we[0][b]) mem0[ram_addr0][b*8 +: 8] <= ram_wdata[0][b*8 +: 8];
            if (en[1] && ram_we[1][b]) mem1[ram_addr1][b*8 +: 8] <= ram_wdata[1][b*8 +: 8];
        end
    end

    function automatic logic [31:0] addr_of(input int k);
        return (k == 0) ? {22'h0, ram_addr0} : {24'h0, ram_addr1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k);
        chk("rst_ctl", {29'h0, ack[k], err[k], en[k]}, 32'h0);
        chk("rst_dat", dat_o[k], 32'h0);
        chk("rst_ramwe", {28'h0, ram_we[k]}, 32'h0);
        chk("rst_ramaddr", addr_of(k), 32'h0);
        chk("rst_wdata", ram_wdata[k], 32'h0);
    endtask

    // mode 0: normal, 1: drop cyc/stb after stop_at edges, 2: assert reset after stop_at edges
    task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int mode, input int stop_at,
                          output logic [31:0] rd);
        int lat, aw, idx, exp_edge, term_edge, extra, en_cnt;
        bit miss, got_ack, got_err, both;
        logic [3:0]  en_we;
        logic [31:0] en_addr, en_wd, exp_rd, dat_term;
        lat = (k == 0) ? 1 : 4;
        aw  = (k == 0) ? 10 : 8;
        idx = int'((a >> 2) & ((32'h1 << aw) - 32'h1));
        miss = (k == 0) && (a >= 32'h0000_1000);
        exp_edge = (miss || w) ? 1 : lat + 1;
        exp_rd = (k == 0) ? ref0[idx] : ref1[idx];
        term_edge = 0; extra = 0; en_cnt = 0; got_ack = 0; got_err = 0; both = 0;
        en_we = 4'h0; en_addr = 32'h0; en_wd = 32'h0; dat_term = 32'h0; rd = 32'h0;
        @(negedge wb_clk);
        adr = a; wdat = d; we = w; sel = s; cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge wb_clk);
            #1;
            if (en[k]) begin
                en_cnt++; en_we = ram_we[k]; en_addr = addr_of(k); en_wd = ram_wdata[k];
            end
            if (ack[k] && err[k]) both = 1;
            if (ack[k] || err[k]) begin
                if (term_edge == 0) begin
                    term_edge = e; got_ack = ack[k]; got_err = err[k]; dat_term = dat_o[k];
                    cyc[k] = 1'b0; stb[k] = 1'b0;
                end else begin
                    extra++;
                end
            end
            if (mode == 1 && e == stop_at) begin
                cyc[k] = 1'b0; stb[k] = 1'b0;
            end
            if (mode == 2 && e == stop_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero(k);
                cyc[k] = 1'b0; stb[k] = 1'b0;
                last_rd[0] = 32'h0; last_rd[1] = 32'h0;
                @(negedge wb_clk);
                rst_n = 1'b1;
                break;
            end
        end
        if (mode == 0) begin
            chk("term_edge", 32'(term_edge), 32'(exp_edge));
            chk("ack_err", {30'h0, got_ack, got_err}, miss ? 32'h1 : 32'h2);
            chk("one_term", {31'h0, both} + 32'(extra), 32'h0);
            chk("en_pulses", 32'(en_cnt), miss ? 32'h0 : 32'h1);
            if (!miss) begin
                chk("ram_addr", en_addr, 32'(idx));
                chk("ram_we", {28'h0, en_we}, w ? {28'h0, s} : 32'h0);
                if (w) chk("ram_wdata", en_wd, d);
            end
            if (!miss && !w) begin
                chk("rd_data", dat_term, exp_rd);
                last_rd[k] = exp_rd;
                rd = dat_term;
            end else begin
                chk("dat_hold", dat_term, last_rd[k]);
            end
            if (!miss && w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) begin
                        if (k == 0) ref0[idx][b*8 +: 8] = d[b*8 +: 8];
                        else        ref1[idx][b*8 +: 8] = d[b*8 +: 8];
                    end
                end
            end
        end else if (mode == 1) begin
            chk("abort_noterm", 32'(term_edge + extra), 32'h0);
            chk("abort_dat", dat_o[k], last_rd[k]);
            chk("abort_en", 32'(en_cnt), 32'h1);
        end else begin
            chk("rst_noterm", 32'(term_edge), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] rd, a;
        bit w;
        int k;
        for (int i = 0; i < 1024; i++) begin mem0[i] = 32'h0; ref0[i] = 32'h0; end
        for (int i = 0; i < 256; i++)  begin mem1[i] = 32'h0; ref1[i] = 32'h0; end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;

        #3;
        chk_zero(0);
        chk_zero(1);
        @(negedge wb_clk);
        rst_n = 1'b1;

        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, rd);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, rd);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        access(0, 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 0, 0, rd);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, rd);
        chk("rd_merge", rd, 32'hDEAD_ABEF);
        access(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 0, rd);
        access(0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 0, 0, rd);
        access(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h0, 0, 0, rd);

        access(1, 1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 0, 0, rd);
        access(1, 1'b0, 32'h0001_0008, 32'h0, 4'hF, 0, 0, rd);
        chk("rd_l4", rd, 32'h5555_AAAA);
        access(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, 2, rd);
        access(1, 1'b0, 32'hFFFF_FC08, 32'h0, 4'h0, 0, 0, rd);
        chk("rd_alias", rd, 32'h5555_AAAA);

        access(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 2, 2, rd);
        chk_zero(0);
        access(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, rd);
        chk("rd_after_rst", rd, 32'h5555_AAAA);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            if (k == 0) begin
                if (($urandom % 4) != 0) a = a & 32'h0000_003C;
            end else begin
                a = a & 32'hFFFF_FC3C;
            end
            access(k, w, a, $urandom, 4'($urandom), 0, 0, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
